// File: rtl/axis_fifo_buffer.sv
// AXI-Stream slave input into a small first-word-fall-through FIFO with a strobe-based read port.
// Optional occupancy output o_fifo_count when AXIS_FIFO_COUNT_EN is defined.
module axis_fifo_buffer #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  input  logic                       i_axis_tlast,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  input  logic                       i_fifo_r_stb,
  output logic [AXIS_DATA_WIDTH-1:0] o_fifo_r_data,
  output logic                       o_fifo_r_last,
  output logic                       o_fifo_empty,
  output logic                       o_fifo_not_empty,
  output logic                       o_fifo_full,
`ifdef AXIS_FIFO_COUNT_EN
  output logic                       o_fifo_not_full,
  output logic [$clog2(DEPTH):0]     o_fifo_count
`else
  output logic                       o_fifo_not_full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]              wptr;
  logic [AW:0]              rptr;
  logic [AXIS_DATA_WIDTH:0] mem [DEPTH];
  logic                     push;
  logic                     pop;

  assign o_fifo_empty     = (wptr == rptr);
  assign o_fifo_not_empty = ~o_fifo_empty;
  assign o_fifo_full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign o_fifo_not_full  = ~o_fifo_full;

  // Handshake: a beat transfers on a rising edge where i_axis_tvalid && o_axis_tready;
  // tready never depends on tvalid and is held low while rst is asserted.
  assign o_axis_tready = o_fifo_not_full & rst;

  // Clear wins over any same-cycle write or pop.
  assign push = i_axis_tvalid & o_axis_tready & ~i_clear;
  assign pop  = i_fifo_r_stb & o_fifo_not_empty & ~i_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (i_clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {i_axis_tlast, i_axis_tdata};
  end

  assign {o_fifo_r_last, o_fifo_r_data} = mem[rptr[AW-1:0]];

`ifdef AXIS_FIFO_COUNT_EN
  assign o_fifo_count = wptr - rptr;
`endif

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// Scoreboard bench for axis_fifo_buffer: a model occupancy count and an expected
// {last,data} queue are updated as stimulus is driven and checked against the read port.
module tb_axis_fifo_buffer;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          i_clear;
  logic          i_axis_tvalid;
  logic          o_axis_tready;
  logic          i_axis_tlast;
  logic [W-1:0]  i_axis_tdata;
  logic          i_fifo_r_stb;
  logic [W-1:0]  o_fifo_r_data;
  logic          o_fifo_r_last;
  logic          o_fifo_empty;
  logic          o_fifo_not_empty;
  logic          o_fifo_full;
  logic          o_fifo_not_full;
`ifdef AXIS_FIFO_COUNT_EN
  logic [AW:0]   o_fifo_count;
`endif

  axis_fifo_buffer #(.AXIS_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_clear          (i_clear),
    .i_axis_tvalid    (i_axis_tvalid),
    .o_axis_tready    (o_axis_tready),
    .i_axis_tlast     (i_axis_tlast),
    .i_axis_tdata     (i_axis_tdata),
    .i_fifo_r_stb     (i_fifo_r_stb),
    .o_fifo_r_data    (o_fifo_r_data),
    .o_fifo_r_last    (o_fifo_r_last),
    .o_fifo_empty     (o_fifo_empty),
    .o_fifo_not_empty (o_fifo_not_empty),
    .o_fifo_full      (o_fifo_full),
`ifdef AXIS_FIFO_COUNT_EN
    .o_fifo_not_full  (o_fifo_not_full),
    .o_fifo_count     (o_fifo_count)
`else
    .o_fifo_not_full  (o_fifo_not_full)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W:0] exp_q[$];
  int         model_cnt;
  int         n_cmp;
  int         n_err;
  int         n_pops;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag, input logic in_reset);
    check({tag, ".empty"},     64'(o_fifo_empty),     64'(model_cnt == 0));
    check({tag, ".not_empty"}, 64'(o_fifo_not_empty), 64'(model_cnt != 0));
    check({tag, ".full"},      64'(o_fifo_full),      64'(model_cnt == DEPTH));
    check({tag, ".not_full"},  64'(o_fifo_not_full),  64'(model_cnt != DEPTH));
    check({tag, ".tready"},    64'(o_axis_tready),    64'(!in_reset && model_cnt != DEPTH));
`ifdef AXIS_FIFO_COUNT_EN
    check({tag, ".count"},     64'(o_fifo_count),     64'(model_cnt));
`endif
  endtask

  // Called just after a falling edge: drive inputs, check, then advance one clock.
  task automatic cycle(input logic vld, input logic last, input logic [W-1:0] data,
                       input logic stb, input logic clr);
    logic accept;
    logic do_pop;
    logic [W:0] head;
    i_axis_tvalid = vld;
    i_axis_tlast  = last;
    i_axis_tdata  = data;
    i_fifo_r_stb  = stb;
    i_clear       = clr;
    #1;
    check_flags("cyc", 1'b0);
    accept = vld && (model_cnt < DEPTH) && !clr;
    do_pop = stb && (model_cnt > 0) && !clr;
    if (stb && model_cnt > 0) begin
      head = exp_q[0];
      check("r_data", 64'(o_fifo_r_data), 64'(head[W-1:0]));
      check("r_last", 64'(o_fifo_r_last), 64'(head[W]));
    end
    if (do_pop) begin
      void'(exp_q.pop_front());
      model_cnt--;
      n_pops++;
    end
    if (accept) begin
      exp_q.push_back({last, data});
      model_cnt++;
    end
    if (clr) begin
      exp_q.delete();
      model_cnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; model_cnt = 0; n_pops = 0;
    rst = 1'b0; i_clear = 1'b0; i_axis_tvalid = 1'b1; i_axis_tlast = 1'b0;
    i_axis_tdata = '0; i_fifo_r_stb = 1'b0;

    // 1. reset: tready held low even with tvalid high
    repeat (2) @(negedge clk);
    #1;
    check_flags("reset", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    i_axis_tvalid = 1'b0;
    #1;
    check("reset_release.tready", 64'(o_axis_tready), 64'd1);
    @(negedge clk);

    // 2. fill, then a 5th beat held valid is refused
    for (int i = 0; i < 5; i++)
      cycle(1'b1, (i == 3), W'(32'hA0 + i), 1'b0, 1'b0);
    check("fill.count_model", 64'(exp_q.size()), 64'(DEPTH));
    check_flags("fill_done", 1'b0);

    // 3. drain plus one extra pop while empty
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_flags("drain_done", 1'b0);
    check("drain.pops", 64'(n_pops), 64'(DEPTH));

    // 4. streaming across pointer wrap
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i == 7), W'(32'h10 + i), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_flags("stream_done", 1'b0);

    // 5. clear with 3 entries and a concurrent beat
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, W'(32'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hCC, 1'b0, 1'b1);
    check_flags("after_clear", 1'b0);
    cycle(1'b1, 1'b1, 32'hD0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // 6. asynchronous reset between edges with 2 entries held
    cycle(1'b1, 1'b0, 32'hE0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'hE1, 1'b0, 1'b0);
    i_axis_tvalid = 1'b0;
    #2 rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    #1;
    check_flags("async_reset", 1'b1);
    #1 rst = 1'b1;
    @(negedge clk);
    idle();

    // random traffic with occasional clear
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
    for (int i = 0; i < 2 * DEPTH && model_cnt > 0; i++)
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_flags("final", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
